// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - directed-table plus LFSR stimulus/check controller for the file datapath
module vector_sequencer #(
    parameter int WIDTH     = 8,
    parameter int X_WIDTH   = 5,
    parameter int VEC_DEPTH = 10,
    parameter int RAND_CNT  = 30,
    parameter int LAT       = 1,
    localparam int STIM_W   = WIDTH + 2 + X_WIDTH,
    localparam int EXP_W    = WIDTH + 2,
    localparam int AW       = $clog2(VEC_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      cfg_we,
    input  logic [AW-1:0]             cfg_addr,
    input  logic [STIM_W+EXP_W-1:0]   cfg_wdata,
    output logic [WIDTH-1:0]          data_in,
    output logic                      a,
    output logic                      b,
    output logic [X_WIDTH-1:0]        x,
    input  logic [WIDTH-1:0]          data_out,
    input  logic                      out,
    input  logic                      d,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [31:0]               vecnum,
    output logic [31:0]               errors
);
    localparam int ENT_W = STIM_W + EXP_W;
    localparam int RW    = $clog2(RAND_CNT + 1);
    localparam logic [AW:0]   DEPTH_L    = (AW+1)'(VEC_DEPTH);
    localparam logic [AW-1:0] LAST_IDX   = AW'(VEC_DEPTH - 1);
    localparam logic [2:0]    DRAIN_LAST = 3'(LAT - 1);
    localparam logic [RW-1:0] RAND_LAST  = RW'(RAND_CNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIRECT,
        S_DRAIN,
        S_RANDOM,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [AW-1:0]       idx_q;
    logic [2:0]          drain_q;
    logic [RW-1:0]       rcnt_q;
    logic [STIM_W-1:0]   stim_q;
    logic [15:0]         lfsr_q;
    logic [15:0]         lfsr_d;
    logic [EXP_W-1:0]    exp_q [LAT];
    logic [LAT-1:0]      vld_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [31:0]         vecnum_q;
    logic [31:0]         errors_q;
    logic [31:0]         errors_d;
    logic [ENT_W-1:0]    table_q [VEC_DEPTH];

    logic [ENT_W-1:0]    entry;
    logic [STIM_W-1:0]   entry_stim;
    logic [EXP_W-1:0]    entry_exp;
    logic                cmp_active;
    logic                mismatch;

    assign {data_in, a, b, x} = stim_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign pass   = pass_q;
    assign vecnum = vecnum_q;
    assign errors = errors_q;

    // Table read, LFSR next value and compare/saturating error count
    always_comb begin
        entry      = table_q[idx_q];
        entry_stim = entry[ENT_W-1:EXP_W];
        entry_exp  = entry[EXP_W-1:0];
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        cmp_active = (state_q == S_DIRECT) || (state_q == S_DRAIN);
        mismatch   = cmp_active && vld_q[LAT-1] && ({data_out, out, d} != exp_q[LAT-1]);
        errors_d   = (mismatch && (errors_q != 32'hFFFF_FFFF)) ? errors_q + 32'd1 : errors_q;
    end

    // Vector table: writable only while idle, out-of-range addresses dropped
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_addr} < DEPTH_L)) begin
            table_q[cfg_addr] <= cfg_wdata;
        end
    end

    // Run sequencing FSM with registered stimulus, status and compare pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            drain_q  <= '0;
            rcnt_q   <= '0;
            stim_q   <= '0;
            lfsr_q   <= 16'hACE1;
            vld_q    <= '0;
            for (int i = 0; i < LAT; i++) exp_q[i] <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            vecnum_q <= '0;
            errors_q <= '0;
        end else begin
            done_q   <= 1'b0;
            errors_q <= errors_d;
            for (int i = LAT - 1; i > 0; i--) begin
                exp_q[i] <= exp_q[i-1];
                vld_q[i] <= vld_q[i-1];
            end
            exp_q[0] <= entry_exp;
            vld_q[0] <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    stim_q <= '0;
                    if (start) begin
                        vecnum_q <= '0;
                        errors_q <= '0;
                        pass_q   <= 1'b0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_DIRECT;
                    end
                end
                S_DIRECT: begin
                    stim_q   <= entry_stim;
                    vld_q[0] <= 1'b1;
                    vecnum_q <= vecnum_q + 32'd1;
                    if (idx_q == LAST_IDX) begin
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        stim_q  <= lfsr_q[STIM_W-1:0];
                        lfsr_q  <= lfsr_d;
                        rcnt_q  <= RW'(1);
                        state_q <= S_RANDOM;
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                S_RANDOM: begin
                    if (rcnt_q == RAND_LAST) begin
                        stim_q  <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (errors_q == 32'd0);
                        state_q <= S_DONE;
                    end else begin
                        stim_q <= lfsr_q[STIM_W-1:0];
                        lfsr_q <= lfsr_d;
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vector_sequencer.sv
// tb/tb_vector_sequencer.sv - randomized self-checking bench for vector_sequencer
module tb_vector_sequencer;
    localparam int WIDTH     = 8;
    localparam int X_WIDTH   = 5;
    localparam int VEC_DEPTH = 10;
    localparam int RAND_CNT  = 30;
    localparam int LAT       = 1;
    localparam int STIM_W    = 15;
    localparam int EXP_W     = 10;
    localparam int AW        = 4;
    localparam int RUN_LEN   = VEC_DEPTH + LAT + RAND_CNT + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    cfg_we;
    logic [AW-1:0]           cfg_addr;
    logic [STIM_W+EXP_W-1:0] cfg_wdata;
    logic [WIDTH-1:0]        data_in;
    logic                    a;
    logic                    b;
    logic [X_WIDTH-1:0]      x;
    logic [WIDTH-1:0]        data_out;
    logic                    out;
    logic                    d;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [31:0]             vecnum;
    logic [31:0]             errors;

    logic                    tie;
    logic [STIM_W-1:0]       m_stim [VEC_DEPTH];
    logic [EXP_W-1:0]        m_exp  [VEC_DEPTH];
    logic [15:0]             m_lfsr;
    int                      checks = 0;
    int                      errs   = 0;

    vector_sequencer #(
        .WIDTH(WIDTH), .X_WIDTH(X_WIDTH), .VEC_DEPTH(VEC_DEPTH),
        .RAND_CNT(RAND_CNT), .LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .data_in(data_in), .a(a), .b(b), .x(x),
        .data_out(data_out), .out(out), .d(d),
        .busy(busy), .done(done), .pass(pass),
        .vecnum(vecnum), .errors(errors)
    );

    always #5 clk = ~clk;

    // Stand-in datapath: sum/and/or of the stimulus, or a stuck all-ones response
    function automatic logic [EXP_W-1:0] ref_resp(input logic [STIM_W-1:0] s, input logic t);
        logic [7:0] sum;
        if (t) return 10'h3FF;
        sum = 8'((int'(s[14:7]) + int'(s[4:0]) + int'(s[6])) % 256);
        return {sum, s[6] & s[5], s[6] | s[5]};
    endfunction

    assign {data_out, out, d} = ref_resp({data_in, a, b, x}, tie);

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int fb;
        fb = ((int'(s) >> 15) ^ (int'(s) >> 13) ^ (int'(s) >> 12) ^ (int'(s) >> 10)) & 1;
        return 16'((int'(s) * 2 + fb) % 65536);
    endfunction

    function automatic int model_errors();
        int n = 0;
        for (int k = 0; k < VEC_DEPTH; k++)
            if (ref_resp(m_stim[k], tie) !== m_exp[k]) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input int idx, input logic [STIM_W-1:0] st, input logic [EXP_W-1:0] ex);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(idx);
        cfg_wdata = {st, ex};
        @(negedge clk);
        cfg_we    = 1'b0;
        if (idx < VEC_DEPTH) begin
            m_stim[idx] = st;
            m_exp[idx]  = ex;
        end
    endtask

    task automatic run_check(input string tag, input bit poke);
        int exp_err;
        int busy_n;
        int done_n;
        int done_at;
        exp_err = model_errors();
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "/busy_at_start"}, busy, 1);
        check({tag, "/errors_cleared"}, errors, 0);
        check({tag, "/vecnum_cleared"}, vecnum, 0);
        busy_n = 1;
        for (int n = 1; n <= RUN_LEN + 2; n++) begin
            @(negedge clk);
            if (poke && n == 5) begin
                start     = 1'b1;
                cfg_we    = 1'b1;
                cfg_addr  = '0;
                cfg_wdata = ~{m_stim[0], m_exp[0]};
            end else if (poke && n == 6) begin
                start  = 1'b0;
                cfg_we = 1'b0;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = n;
            end
            if (n >= 1 && n <= VEC_DEPTH)
                check({tag, "/direct_stim"}, {data_in, a, b, x}, m_stim[n-1]);
            if (n > VEC_DEPTH && n <= VEC_DEPTH + RAND_CNT) begin
                check({tag, "/random_stim"}, {data_in, a, b, x}, m_lfsr[14:0]);
                m_lfsr = lfsr_step(m_lfsr);
            end
            if (n == RUN_LEN - 1)
                check({tag, "/stim_zero_at_done"}, {data_in, a, b, x}, 0);
        end
        check({tag, "/busy_cycles"}, busy_n, RUN_LEN - 1);
        check({tag, "/done_count"}, done_n, 1);
        check({tag, "/done_cycle"}, done_at, RUN_LEN - 1);
        check({tag, "/vecnum"}, vecnum, VEC_DEPTH);
        check({tag, "/errors"}, errors, exp_err);
        check({tag, "/pass"}, pass, (exp_err == 0));
    endtask

    initial begin
        logic [STIM_W-1:0] st;
        bit found;
        int done_n;
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; tie = 1'b0;
        m_lfsr = 16'hACE1;
        repeat (3) @(negedge clk);
        check("reset/busy", busy, 0);
        check("reset/done", done, 0);
        check("reset/pass", pass, 0);
        check("reset/vecnum", vecnum, 0);
        check("reset/errors", errors, 0);
        check("reset/stim", {data_in, a, b, x}, 0);
        rst = 1'b0;

        for (int k = 0; k < VEC_DEPTH; k++) begin
            st = STIM_W'($urandom);
            write_entry(k, st, ref_resp(st, 1'b0));
        end
        run_check("clean", 1'b0);

        write_entry(3, m_stim[3], m_exp[3] ^ 10'h001);
        run_check("corrupt_d", 1'b0);

        for (int k = 0; k < VEC_DEPTH; k++) write_entry(k, m_stim[k], '0);
        tie = 1'b1;
        run_check("tied_high", 1'b0);
        tie = 1'b0;
        for (int k = 0; k < VEC_DEPTH; k++) write_entry(k, m_stim[k], ref_resp(m_stim[k], 1'b0));
        run_check("fixed", 1'b0);

        run_check("busy_poke", 1'b1);
        run_check("after_poke", 1'b0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (vecnum == 32'd6) found = 1'b1;
        end
        check("midrun/reached_vector5", found, 1);
        rst = 1'b1;
        #1;
        check("midrun/busy", busy, 0);
        check("midrun/done", done, 0);
        check("midrun/pass", pass, 0);
        check("midrun/vecnum", vecnum, 0);
        check("midrun/errors", errors, 0);
        check("midrun/stim", {data_in, a, b, x}, 0);
        #1;
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        done_n = 0;
        for (int i = 0; i < RUN_LEN + 5; i++) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        check("midrun/stays_idle", done_n, 0);
        run_check("after_reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Stimulus/check controller for the `file` datapath (clk, rst, data_in, a, b, x -> data_out, out, d).
- Holds a loadable table of directed vectors with expected responses and applies one vector per clock to the datapath.
- Compares the returned outputs after a fixed latency, then runs a pseudo-random phase.
- Reports vector count, error count, busy, done and pass, so the datapath can be exercised in-system without a simulator file loader.

Parameters:
- WIDTH, 8, width of data_in/data_out.
- X_WIDTH, 5, width of x.
- VEC_DEPTH, 10, number of directed vector entries.
- RAND_CNT, 30, number of random-phase cycles.
- LAT, 1, clock cycles from a vector being driven to its response being sampled (1..4).
- Derived: STIM_W = WIDTH+2+X_WIDTH (15); EXP_W = WIDTH+2 (10); AW = $clog2(VEC_DEPTH). STIM_W must be <= 16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request, sampled in IDLE only.
- cfg_we  in  1  table write enable.
- cfg_addr  in  AW  table write address.
- cfg_wdata  in  STIM_W+EXP_W  {stimulus {data_in,a,b,x}, expected {data_out,out,d}}.
- data_in  out  WIDTH  stimulus to the datapath.
- a  out  1  stimulus.
- b  out  1  stimulus.
- x  out  X_WIDTH  stimulus.
- data_out  in  WIDTH  datapath response.
- out  in  1  datapath response.
- d  in  1  datapath response.
- busy  out  1  high in DIRECT/DRAIN/RANDOM.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  level: last run finished with errors==0.
- vecnum  out  32  directed vectors applied in current/last run.
- errors  out  32  directed mismatches in current/last run.

Behaviour:
- Reset (async, asserted): state=IDLE; all stimulus outputs 0; busy=0, done=0, pass=0, vecnum=0, errors=0; LFSR=16'hACE1; compare pipeline valid bits cleared. Table contents are not reset.
- Reset asserted mid-run aborts immediately to the same values. No done pulse is generated.
- Table write: on clk while cfg_we=1 and state=IDLE, writes entry[cfg_addr]. Ignored while busy. Ignored when cfg_addr >= VEC_DEPTH.
- IDLE: stimulus held at 0. When start=1: vecnum<=0, errors<=0, pass<=0, go to DIRECT.
- DIRECT:
  - Cycle k (k=0..VEC_DEPTH-1) registers stimulus entry[k] onto the outputs and increments vecnum.
  - Expected entry[k] and a valid bit enter an LAT-deep shift pipeline.
  - After entry VEC_DEPTH-1 is driven, go to DRAIN.
- Compare: at any edge where the pipeline output valid=1, {data_out,out,d} is compared with the delayed expected value. On mismatch, errors increments, saturating at 32'hFFFF_FFFF. Compare is active in DIRECT and DRAIN only.
- DRAIN: stimulus holds the last vector for LAT cycles until the pipeline empties, then go to RANDOM.
- RANDOM:
  - For RAND_CNT cycles, {data_in,a,b,x} <= lfsr[STIM_W-1:0].
  - LFSR advances each cycle: Fibonacci, taps 16,14,13,11, shifts left, feedback into bit 0.
  - No checking; vecnum and errors are frozen.
  - After RAND_CNT cycles go to DONE.
- DONE (1 cycle): done=1, pass<=(errors==0), stimulus returns to 0, busy=0, next state IDLE.
- LFSR is not reseeded between runs; it continues from its last value.
- start while busy is ignored. start held high in IDLE retriggers the next run on the cycle after DONE.
- Simultaneous start and cfg_we in IDLE: the write completes and the run starts; entry usage begins in the next cycle, so the new data is seen.
- Total run length from the start edge to the done pulse: VEC_DEPTH+LAT+RAND_CNT+1 cycles (defaults: 42).

Test Plan:
- Load 10 entries whose expected values equal the reference datapath responses; pulse start. Required: busy for 41 cycles, done pulses once, errors=0, vecnum=10, pass=1.
- Corrupt expected value of entry 3 (flip bit d). Required: errors=1 at run end, pass=0, vecnum=10.
- Tie response inputs to a constant 10'h3FF against all-zero expected values. Required: errors=10. Then rerun with correct expected values. Required: errors cleared to 0 at start, pass=1.
- Assert rst for 2 ns at vector 5 of DIRECT. Required: all outputs 0 immediately, state IDLE, no done pulse. A fresh start then completes a full 42-cycle run.
- Pulse start and cfg_we(addr 0) while busy. Required: no second run, entry 0 unchanged (verified by a rerun with the old expected value giving errors=0).
- Random phase after reset: first three stimulus words equal lfsr[14:0] of successive LFSR states from 16'hACE1. Checked against the bench model, 30 words, then stimulus returns to 0.
